// File: rtl/multi_bank_tile_fetcher_if.sv
// BRAM Port B read bus and output beat stream of the tile fetcher.
// master = fetch engine, slave = BRAM banks plus downstream consumer.
interface multi_bank_tile_fetcher_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 256,
    parameter int NUM_BANKS  = 3
);
    logic [NUM_BANKS-1:0]            bram_en;
    logic [ADDR_WIDTH-1:0]           bram_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0] bram_rdata;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic                            out_last;

    modport master (
        output bram_en, bram_addr, out_data, out_valid, out_last,
        input  bram_rdata, out_ready
    );

    modport slave (
        input  bram_en, bram_addr, out_data, out_valid, out_last,
        output bram_rdata, out_ready
    );
endinterface

// File: rtl/multi_bank_tile_fetcher.sv
// Small synchronous FIFO with flush; head is shown combinationally (zero when empty).
// Latency: push visible at head the cycle after the write edge.
// Backpressure: none internally; the writer must never push when full.
module mbtf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop_vld && !empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_vld, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Strided multi-tile read engine over one of NUM_BANKS BRAMs, beats returned via output FIFO.
// Latency: first out_valid BRAM_LATENCY+1 cycles after the first issue; 1 beat/cycle when unstalled.
// Backpressure: out_ready stalls the FIFO; issue throttles so FIFO occupancy + in-flight never exceeds FIFO_DEPTH.
module multi_bank_tile_fetcher #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 256,
    parameter int NUM_BANKS    = 3,
    parameter int CNT_WIDTH    = 8,
    parameter int BRAM_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                bank_sel,
    input  logic [ADDR_WIDTH-1:0]     cfg_base,
    input  logic [ADDR_WIDTH-1:0]     cfg_stride,
    input  logic [ADDR_WIDTH-1:0]     cfg_tile_stride,
    input  logic [CNT_WIDTH-1:0]      cfg_fetches,
    input  logic [CNT_WIDTH-1:0]      cfg_tiles,
    multi_bank_tile_fetcher_if.master bus,
    output logic                      tile_done,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W:0]     DEPTH_C = FIFO_DEPTH[OCC_W:0];
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t state, state_nxt;

    logic [1:0]            bank_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] tile_stride_q;
    logic [CNT_WIDTH-1:0]  fetches_q;
    logic [CNT_WIDTH-1:0]  tiles_q;
    logic [CNT_WIDTH-1:0]  fetch_cnt;
    logic [CNT_WIDTH-1:0]  tile_cnt;
    logic [ADDR_WIDTH-1:0] addr_acc;
    logic [ADDR_WIDTH-1:0] tile_base;
    logic                  done_q;
    logic                  err_q;

    logic [BRAM_LATENCY-1:0] vld_pipe;
    logic [BRAM_LATENCY-1:0] last_pipe;

    logic                  start_ok, bank_ok, cfg_nz;
    logic                  last_fetch, last_tile;
    logic                  issue, final_issue, pop, room, drain_done;
    logic [OCC_W-1:0]      occ, inflight;
    logic [OCC_W:0]        demand, capacity;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] rdata_sel;
    beat_t                 push_beat, head_beat;

    assign start_ok    = start && !abort && (state == S_IDLE);
    assign bank_ok     = (32'(bank_sel) < NUM_BANKS);
    assign cfg_nz      = (cfg_fetches != '0) && (cfg_tiles != '0);
    assign last_fetch  = (fetch_cnt == fetches_q - CNT_ONE);
    assign last_tile   = (tile_cnt == tiles_q - CNT_ONE);
    assign pop         = !fifo_empty && bus.out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            inflight = inflight + {{(OCC_W-1){1'b0}}, vld_pipe[i]};
        end
    end

    // A same-cycle pop frees a slot, so capacity grows by one when popping.
    assign demand      = {1'b0, occ} + {1'b0, inflight};
    assign capacity    = DEPTH_C + {{OCC_W{1'b0}}, pop};
    assign room        = demand < capacity;
    assign issue       = (state == S_FETCH) && !abort && room;
    assign final_issue = issue && last_fetch && last_tile;
    assign drain_done  = (state == S_DRAIN) && (inflight == '0) && fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start && bank_ok && cfg_nz) state_nxt = S_FETCH;
                S_FETCH: if (final_issue)                state_nxt = S_DRAIN;
                S_DRAIN: if (drain_done)                 state_nxt = S_IDLE;
                default:                                 state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q        <= '0;
            stride_q      <= '0;
            tile_stride_q <= '0;
            fetches_q     <= '0;
            tiles_q       <= '0;
            fetch_cnt     <= '0;
            tile_cnt      <= '0;
            addr_acc      <= '0;
            tile_base     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (start_ok) begin
                if (!bank_ok) begin
                    err_q <= 1'b1;
                end else if (!cfg_nz) begin
                    done_q <= 1'b1;
                end else begin
                    bank_q        <= bank_sel;
                    stride_q      <= cfg_stride;
                    tile_stride_q <= cfg_tile_stride;
                    fetches_q     <= cfg_fetches;
                    tiles_q       <= cfg_tiles;
                    fetch_cnt     <= '0;
                    tile_cnt      <= '0;
                    addr_acc      <= cfg_base;
                    tile_base     <= cfg_base;
                end
            end else if (issue) begin
                // Running accumulators replace base + t*tile_stride + k*stride.
                if (last_fetch) begin
                    fetch_cnt <= '0;
                    tile_cnt  <= tile_cnt + CNT_ONE;
                    tile_base <= tile_base + tile_stride_q;
                    addr_acc  <= tile_base + tile_stride_q;
                end else begin
                    fetch_cnt <= fetch_cnt + CNT_ONE;
                    addr_acc  <= addr_acc + stride_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (abort) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= last_fetch;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == 2'(b)) rdata_sel = bus.bram_rdata[b*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        push_beat.last = last_pipe[BRAM_LATENCY-1];
        push_beat.data = rdata_sel;
    end

    mbtf_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push_vld (vld_pipe[BRAM_LATENCY-1]),
        .push_dat (push_beat),
        .pop_vld  (pop),
        .pop_dat  (head_beat),
        .empty    (fifo_empty),
        .count    (occ)
    );

    always_comb begin
        bus.bram_en = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (issue && (bank_q == 2'(b))) bus.bram_en[b] = 1'b1;
        end
    end

    assign bus.bram_addr = addr_acc;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head_beat.data;
    assign bus.out_last  = head_beat.last;

    assign tile_done = pop && head_beat.last;
    assign busy      = (state != S_IDLE);
    assign done      = (drain_done && !abort) || done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_multi_bank_tile_fetcher.sv
// Directed bench for multi_bank_tile_fetcher with a 2-cycle BRAM model and pattern data.
module tb_multi_bank_tile_fetcher;
    localparam int AW  = 11;
    localparam int DW  = 256;
    localparam int NB  = 3;
    localparam int CW  = 8;
    localparam int LAT = 2;
    localparam int FD  = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [1:0]    bank_sel;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_stride;
    logic [AW-1:0] cfg_tile_stride;
    logic [CW-1:0] cfg_fetches;
    logic [CW-1:0] cfg_tiles;
    logic          tile_done;
    logic          busy;
    logic          done;
    logic          err;

    multi_bank_tile_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB)) bif ();

    multi_bank_tile_fetcher #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB),
        .CNT_WIDTH(CW), .BRAM_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .bank_sel        (bank_sel),
        .cfg_base        (cfg_base),
        .cfg_stride      (cfg_stride),
        .cfg_tile_stride (cfg_tile_stride),
        .cfg_fetches     (cfg_fetches),
        .cfg_tiles       (cfg_tiles),
        .bus             (bif),
        .tile_done       (tile_done),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(int b, int a);
        logic [31:0] w;
        w = {8'(b), 5'd0, 11'(a), 8'(~a)};
        return {8{w}};
    endfunction

    // Two-stage BRAM read model: address register then output register.
    logic [DW-1:0] st1 [NB];
    logic [DW-1:0] dq  [NB];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bif.bram_en[b]) st1[b] <= pat(b, int'(bif.bram_addr));
            dq[b] <= st1[b];
        end
    end
    assign bif.bram_rdata = {dq[2], dq[1], dq[0]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] iss_addr [$];
    logic [NB-1:0] iss_en   [$];
    int            iss_cyc  [$];
    logic [DW-1:0] acc_dat  [$];
    bit            acc_last [$];
    int            acc_cyc  [$];
    int td_cnt = 0, done_cnt = 0, err_cnt = 0, unstable = 0, bad_td = 0;
    int max_out = 0, outstanding = 0, last_td_cyc = 0, last_done_cyc = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.bram_en != '0) begin
                iss_addr.push_back(bif.bram_addr);
                iss_en.push_back(bif.bram_en);
                iss_cyc.push_back(cyc);
                outstanding++;
            end
            if (bif.out_valid && bif.out_ready) begin
                acc_dat.push_back(bif.out_data);
                acc_last.push_back(bif.out_last);
                acc_cyc.push_back(cyc);
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (!busy && !bif.out_valid) outstanding = 0;
            if (tile_done) begin
                td_cnt++;
                last_td_cyc = cyc;
                if (!(bif.out_valid && bif.out_ready && bif.out_last)) bad_td++;
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (err) err_cnt++;
            if (prev_stall && (!bif.out_valid || bif.out_data !== prev_dat || bif.out_last !== prev_last))
                unstable++;
            prev_stall = bif.out_valid && !bif.out_ready;
            prev_dat   = bif.out_data;
            prev_last  = bif.out_last;
        end else begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(int b, int base, int st, int ts, int f, int t);
        bank_sel        = 2'(b);
        cfg_base        = AW'(base);
        cfg_stride      = AW'(st);
        cfg_tile_stride = AW'(ts);
        cfg_fetches     = CW'(f);
        cfg_tiles       = CW'(t);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // mode 0: ready held high; 1: toggles 1/0; 2: high one cycle in four.
    task automatic run_to_done(string tag, int mode, int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            case (mode)
                1:       bif.out_ready = (k % 2 == 0);
                2:       bif.out_ready = (k % 4 == 3);
                default: bif.out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (done) got = 1'b1;
            @(posedge clk);
            #1;
        end
        bif.out_ready = 1'b1;
        chk({tag, "_done_seen"}, int'(got), 1);
    endtask

    task automatic check_job(string tag, int i0, int a0, int b, int base, int st, int ts, int f, int t);
        int bad_a, bad_e, bad_d, bad_l, idx;
        logic [AW-1:0] ea;
        bad_a = 0; bad_e = 0; bad_d = 0; bad_l = 0;
        chk({tag, "_issues"}, iss_addr.size() - i0, f * t);
        chk({tag, "_beats"},  acc_dat.size() - a0,  f * t);
        for (int ti = 0; ti < t; ti++) begin
            for (int k = 0; k < f; k++) begin
                idx = ti * f + k;
                ea  = AW'(base + ti * ts + k * st);
                if (i0 + idx < iss_addr.size()) begin
                    if (iss_addr[i0 + idx] !== ea)        bad_a++;
                    if (iss_en[i0 + idx] !== NB'(1 << b)) bad_e++;
                end else begin
                    bad_a++;
                end
                if (a0 + idx < acc_dat.size()) begin
                    if (acc_dat[a0 + idx] !== pat(b, int'(ea))) bad_d++;
                    if (acc_last[a0 + idx] != (k == f - 1))     bad_l++;
                end else begin
                    bad_d++;
                end
            end
        end
        chk({tag, "_addr_errs"}, bad_a, 0);
        chk({tag, "_en_errs"},   bad_e, 0);
        chk({tag, "_data_errs"}, bad_d, 0);
        chk({tag, "_last_errs"}, bad_l, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, a0, i1, a1, td0, d0, e0, diff;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bank_sel = '0;
        cfg_base = '0; cfg_stride = '0; cfg_tile_stride = '0;
        cfg_fetches = '0; cfg_tiles = '0;
        bif.out_ready = 1'b1;
        step(3);

        chk("rst_busy",      int'(busy), 0);
        chk("rst_out_valid", int'(bif.out_valid), 0);
        chk("rst_bram_en",   int'(bif.bram_en), 0);
        chk("rst_bram_addr", int'(bif.bram_addr), 0);
        chk("rst_out_data",  int'(bif.out_data != '0), 0);
        chk("rst_flags",     int'({done, err, tile_done, bif.out_last}), 0);
        rst_n = 1'b1;
        step(2);

        // Two contiguous 32-beat tiles from bank 1.
        i0 = iss_addr.size(); a0 = acc_dat.size(); td0 = td_cnt; d0 = done_cnt;
        go(1, 112, 1, 32, 32, 2);
        run_to_done("t1", 0, 300);
        step(2);
        check_job("t1", i0, a0, 1, 112, 1, 32, 32, 2);
        chk("t1_span", (iss_cyc.size() >= i0 + 64) ? iss_cyc[i0 + 63] - iss_cyc[i0] : -1, 63);
        chk("t1_first_lat", (acc_cyc.size() > a0 && iss_cyc.size() > i0) ? acc_cyc[a0] - iss_cyc[i0] : -1, LAT + 1);
        chk("t1_tile_done", td_cnt - td0, 2);
        chk("t1_done_once", done_cnt - d0, 1);
        diff = last_done_cyc - last_td_cyc;
        chk("t1_done_order", int'(diff == 0 || diff == 1), 1);
        chk("t1_idle", int'(busy), 0);

        // Address wrap at 2^11.
        i0 = iss_addr.size(); a0 = acc_dat.size(); td0 = td_cnt;
        go(0, 2040, 4, 0, 4, 1);
        run_to_done("t2", 0, 100);
        step(2);
        check_job("t2", i0, a0, 0, 2040, 4, 0, 4, 1);
        chk("t2_tile_done", td_cnt - td0, 1);

        // Toggled ready.
        i0 = iss_addr.size(); a0 = acc_dat.size();
        go(2, 100, 3, 50, 10, 2);
        run_to_done("t3", 1, 400);
        step(2);
        check_job("t3", i0, a0, 2, 100, 3, 50, 10, 2);

        // Heavy stall: FIFO plus in-flight must reach, but never exceed, FIFO_DEPTH.
        i0 = iss_addr.size(); a0 = acc_dat.size();
        go(0, 1900, 7, 300, 6, 3);
        run_to_done("t3b", 2, 600);
        step(2);
        check_job("t3b", i0, a0, 0, 1900, 7, 300, 6, 3);
        chk("t3_max_outstanding", max_out, FD);
        chk("t3_stable_stall", unstable, 0);

        // Abort mid-job.
        i0 = iss_addr.size(); d0 = done_cnt;
        go(0, 0, 1, 0, 32, 1);
        step(4);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t4_abort_busy",  int'(busy), 0);
        chk("t4_abort_valid", int'(bif.out_valid), 0);
        chk("t4_abort_en",    int'(bif.bram_en), 0);
        i1 = iss_addr.size(); a1 = acc_dat.size();
        chk("t4_issued_before", int'(i1 > i0), 1);
        step(10);
        chk("t4_no_issue_after", iss_addr.size() - i1, 0);
        chk("t4_no_beat_after",  acc_dat.size() - a1, 0);
        chk("t4_no_done",        done_cnt - d0, 0);
        i0 = iss_addr.size(); a0 = acc_dat.size();
        go(2, 10, 2, 0, 5, 1);
        run_to_done("t4_clean", 0, 100);
        step(2);
        check_job("t4_clean", i0, a0, 2, 10, 2, 0, 5, 1);

        // Invalid bank.
        i0 = iss_addr.size(); d0 = done_cnt; e0 = err_cnt;
        go(3, 0, 1, 0, 4, 1);
        chk("t5_err_pulse", int'(err), 1);
        chk("t5_err_busy",  int'(busy), 0);
        step(5);
        chk("t5_err_once",     err_cnt - e0, 1);
        chk("t5_err_no_issue", iss_addr.size() - i0, 0);
        chk("t5_err_no_done",  done_cnt - d0, 0);

        // Zero fetch / zero tile jobs.
        i0 = iss_addr.size(); d0 = done_cnt;
        go(0, 0, 1, 0, 0, 3);
        chk("t5_zf_done", int'(done), 1);
        step(3);
        go(1, 0, 1, 0, 5, 0);
        chk("t5_zt_done", int'(done), 1);
        step(3);
        chk("t5_zero_no_issue", iss_addr.size() - i0, 0);
        chk("t5_zero_done_cnt", done_cnt - d0, 2);
        chk("t5_zero_busy", int'(busy), 0);

        // start while busy is ignored.
        i0 = iss_addr.size(); a0 = acc_dat.size(); d0 = done_cnt;
        go(1, 500, 1, 100, 8, 2);
        step(3);
        go(0, 0, 5, 0, 3, 1);
        run_to_done("t6", 0, 200);
        step(2);
        check_job("t6", i0, a0, 1, 500, 1, 100, 8, 2);
        chk("t6_done_once", done_cnt - d0, 1);

        // Asynchronous reset mid-job.
        d0 = done_cnt;
        go(2, 0, 1, 0, 20, 1);
        step(6);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_busy",  int'(busy), 0);
        chk("t7_rst_valid", int'(bif.out_valid), 0);
        chk("t7_rst_en",    int'(bif.bram_en), 0);
        step(1);
        rst_n = 1'b1;
        step(10);
        chk("t7_no_done", done_cnt - d0, 0);
        chk("t7_idle",    int'(busy), 0);
        i0 = iss_addr.size(); a0 = acc_dat.size();
        go(1, 7, 1, 0, 3, 1);
        run_to_done("t7_after", 0, 100);
        step(2);
        check_job("t7_after", i0, a0, 1, 7, 1, 0, 3, 1);

        chk("tile_done_with_last", bad_td, 0);
        chk("stable_stall_total",  unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multi_bank_tile_fetcher.md
Name: multi_bank_tile_fetcher

Overview:
- Next-generation fetch engine for the W/B/I buffer read path.
- Generates strided read addresses over a selectable bank among NUM_BANKS dual-port BRAMs.
- Walks a programmable number of tiles, each with a programmable fetch count.
- Returns read data as a valid/ready stream with backpressure, via a credit-controlled output FIFO that absorbs BRAM read latency.
- Sits between the BRAM banks (Port B) and the systolic/compute datapath, replacing the fixed-count, single-bank fetch logic.

Parameters:
ADDR_WIDTH, 11, BRAM Port B address width
DATA_WIDTH, 256, BRAM Port B data width
NUM_BANKS, 3, number of selectable BRAM banks (1..4)
CNT_WIDTH, 8, width of fetch-count and tile-count configuration fields
BRAM_LATENCY, 1, BRAM read latency in cycles from en/addr to dout (1 or 2)
FIFO_DEPTH, 4, output FIFO entries; must be >= BRAM_LATENCY+1, power of two

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; latches cfg_* and bank_sel, begins job
abort  in  1  synchronous flush; returns to IDLE next cycle
bank_sel  in  2  target bank index
cfg_base  in  ADDR_WIDTH  first address of tile 0
cfg_stride  in  ADDR_WIDTH  address increment between fetches within a tile
cfg_tile_stride  in  ADDR_WIDTH  address increment between tile start addresses
cfg_fetches  in  CNT_WIDTH  fetches per tile
cfg_tiles  in  CNT_WIDTH  tiles per job
bram_en  out  NUM_BANKS  one-hot Port B enable, bit bank_sel only
bram_addr  out  ADDR_WIDTH  Port B address, shared by all banks
bram_rdata  in  NUM_BANKS*DATA_WIDTH  concatenated Port B dout, bank 0 in LSBs
out_data  out  DATA_WIDTH  FIFO head data
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts when out_valid && out_ready
out_last  out  1  head entry is the last fetch of its tile
tile_done  out  1  one-cycle pulse when the last beat of a tile is accepted
busy  out  1  high in FETCH or DRAIN
done  out  1  one-cycle pulse on job completion
err  out  1  one-cycle pulse when start is rejected for bank_sel >= NUM_BANKS

Behaviour:
- Reset values: bram_en=0, bram_addr=0, out_valid=0, out_last=0, out_data=0, tile_done=0, busy=0, done=0, err=0; FSM=IDLE; FIFO empty; in-flight counter=0.
- States:
  - IDLE -> FETCH on start with valid bank and nonzero cfg_fetches and cfg_tiles.
  - FETCH -> DRAIN after the final address is issued.
  - DRAIN -> IDLE when in-flight=0, FIFO empty, and the last beat has been accepted; done pulses in that same cycle.
- Start in IDLE with cfg_fetches=0 or cfg_tiles=0: no reads issued; done pulses the next cycle.
- Start in IDLE with bank_sel >= NUM_BANKS: no reads; err pulses the next cycle; done stays low.
- start while busy: ignored. Configuration and bank are latched at start; cfg_* changes mid-job have no effect.
- Issue rule: a read is issued in a FETCH cycle iff (FIFO occupancy + in-flight) < FIFO_DEPTH, counting a same-cycle pop as freeing a slot. Issue means bram_en[bank]=1 with bram_addr valid in that cycle. Because of this rule the FIFO never overflows.
- Address sequence: tile t, fetch k issues base + t*tile_stride + k*stride, computed modulo 2^ADDR_WIDTH (silent wrap). Implemented with running accumulators; no multipliers.
- Read data is captured from the latched bank's slice of bram_rdata exactly BRAM_LATENCY cycles after issue, via a BRAM_LATENCY-deep valid/last shift pipeline. The last tag travels with the fetch.
- First out_valid occurs BRAM_LATENCY+1 cycles after the first issue (registered FIFO write). With out_ready held high, throughput is 1 beat/cycle.
- Simultaneous FIFO push and pop: occupancy unchanged. Data order is strictly preserved.
- out_data, out_last and out_valid must hold stable while out_valid && !out_ready.
- tile_done coincides with acceptance of a beat whose out_last=1. done coincides with the tile_done of the final tile, or follows it.
- abort, in any state: next cycle FSM=IDLE, FIFO and in-flight pipeline cleared, out_valid=0, bram_en=0. No done pulse. Data already in flight is discarded. abort has priority over start in the same cycle.
- Asynchronous reset mid-job: all state returns to reset values immediately; no spurious done on release.

Test Plan:
- bank_sel=1, base=112, stride=1, tile_stride=32, fetches=32, tiles=2, out_ready=1 -> bram_en=3'b010 for 64 cycles; addresses 112..175 contiguous; 64 beats; tile_done after beats 32 and 64; done once.
- base=2040, stride=4, fetches=4, tiles=1 (ADDR_WIDTH=11) -> addresses 2040, 2044, 0, 4 (wrap); 4 beats, last beat with out_last=1.
- Same job with out_ready toggled 1/0 each cycle, BRAM_LATENCY=2 -> never more than FIFO_DEPTH=4 issued-but-unaccepted; data matches a preloaded pattern in order; out_data stable while stalled.
- abort asserted on cycle 5 of a 32-fetch job -> next cycle busy=0, out_valid=0, bram_en=0, no done. A following start runs a full clean job.
- start with bank_sel=3 and NUM_BANKS=3 -> err pulse, no bram_en. start with cfg_fetches=0 -> done after 1 cycle, no reads.
- start reasserted mid-job with different cfg -> ignored; original address sequence completes unchanged.
